// File: rtl/regfile_32x64_if.sv
// rtl/regfile_32x64_if.sv - Write/read port bundle for the 32x64 register file.
// master drives indices and write data; slave returns the read data.
interface regfile_32x64_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [WIDTH-1:0]  WriteData;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [WIDTH-1:0]  ReadData1;
  logic [WIDTH-1:0]  ReadData2;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/regfile_32x64.sv
// rtl/regfile_32x64.sv - LEGv8 register file, two combinational reads, one clocked write, XZR at top index.
// Optional same-cycle write-through forwarding enabled by defining REGFILE_BYPASS_EN.
module regfile_32x64 #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input logic           clk,
  input logic           reset,
  regfile_32x64_if.slave rf
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ZR_IDX = ADDR_W'(DEPTH - 1);

  // The top index has no storage; only DEPTH-1 registers exist.
  logic [WIDTH-1:0] regs_q [DEPTH-1];
  logic [WIDTH-1:0] regs_d [DEPTH-1];
  logic [DEPTH-2:0] wr_sel;

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      wr_sel[i] = rf.RegWrite && (rf.WriteRegister == ADDR_W'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      regs_d[i] = wr_sel[i] ? rf.WriteData : regs_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  function automatic logic [WIDTH-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [WIDTH-1:0]  wdata,
    input logic              rst
  );
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (addr == ADDR_W'(i)) v = regs_q[i];
    end
`ifdef REGFILE_BYPASS_EN
    if (we && (waddr == addr) && (addr != ZR_IDX)) v = wdata;
`else
    if (we && (waddr == addr) && (wdata == '1)) v = v;
`endif
    if (rst) v = '0;
    return v;
  endfunction

  always_comb begin
    rf.ReadData1 = read_port(rf.ReadRegister1, rf.RegWrite, rf.WriteRegister, rf.WriteData, reset);
    rf.ReadData2 = read_port(rf.ReadRegister2, rf.RegWrite, rf.WriteRegister, rf.WriteData, reset);
  end
endmodule

// File: tb/tb_regfile_32x64.sv
// tb/tb_regfile_32x64.sv - Directed and randomized checks of regfile_32x64 against an array model.
// Expectations follow REGFILE_BYPASS_EN when the same macro is defined for the bench.
module tb_regfile_32x64;
  logic clk;
  logic reset;
  logic clk_en;
  int   passed;
  int   total;
  logic [63:0] model [32];

  regfile_32x64_if #(.WIDTH(64), .DEPTH(32)) bus ();

  regfile_32x64 #(.WIDTH(64), .DEPTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask

  // Reference: stored value, XZR reads 0, reset forces 0, optional write-through.
  function automatic logic [63:0] expect_rd(input logic [4:0] a);
    logic [63:0] v;
    v = (a == 5'd31) ? 64'd0 : model[a];
`ifdef REGFILE_BYPASS_EN
    if (bus.RegWrite === 1'b1 && bus.WriteRegister == a && a != 5'd31) v = bus.WriteData;
`endif
    if (reset) v = 64'd0;
    return v;
  endfunction

  task automatic rd(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    bus.ReadRegister1 = a1;
    bus.ReadRegister2 = a2;
    #1;
    check({tag, "_p1"}, bus.ReadData1, expect_rd(a1));
    check({tag, "_p2"}, bus.ReadData2, expect_rd(a2));
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d, input logic we);
    @(negedge clk);
    bus.RegWrite      = we;
    bus.WriteRegister = a;
    bus.WriteData     = d;
    @(posedge clk);
    if (we && a != 5'd31) model[a] = d;
    #1 bus.RegWrite = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      bus.ReadRegister1 = 5'(i);
      bus.ReadRegister2 = 5'(31 - i);
      #1;
      check(tag, bus.ReadData1, 64'd0);
      check(tag, bus.ReadData2, 64'd0);
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    clk_en = 1'b0;
    reset  = 1'b0;
    bus.RegWrite      = 1'b0;
    bus.WriteRegister = 5'd0;
    bus.WriteData     = 64'd0;
    bus.ReadRegister1 = 5'd0;
    bus.ReadRegister2 = 5'd0;
    for (int i = 0; i < 32; i++) model[i] = 64'd0;

    // Reset with no clock running.
    #2 reset = 1'b1;
    #1 check_all_zero("reset_no_clk");
    reset  = 1'b0;
    clk_en = 1'b1;

    wr(5'd5, 64'hDEAD_BEEF_0123_4567, 1'b1);
    rd("x5_x6", 5'd5, 5'd6);
    check("x5_value", bus.ReadData1, 64'hDEAD_BEEF_0123_4567);
    check("x6_zero", bus.ReadData2, 64'd0);

    wr(5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    rd("xzr", 5'd31, 5'd31);
    check("xzr_const", bus.ReadData1, 64'd0);

    wr(5'd7, 64'h1234, 1'b0);
    rd("x7_gated", 5'd7, 5'd7);
    check("x7_const", bus.ReadData1, 64'd0);

    // Same-index read and write.
    wr(5'd9, 64'hA, 1'b1);
    @(negedge clk);
    bus.RegWrite      = 1'b1;
    bus.WriteRegister = 5'd9;
    bus.WriteData     = 64'hB;
    bus.ReadRegister1 = 5'd9;
    bus.ReadRegister2 = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x9_pre_p1", bus.ReadData1, 64'hB);
    check("x9_pre_p2", bus.ReadData2, 64'hB);
`else
    check("x9_pre_p1", bus.ReadData1, 64'hA);
    check("x9_pre_p2", bus.ReadData2, 64'hA);
`endif
    @(posedge clk);
    model[9] = 64'hB;
    #1 bus.RegWrite = 1'b0;
    #1;
    check("x9_post_p1", bus.ReadData1, 64'hB);
    check("x9_post_p2", bus.ReadData2, 64'hB);

    // Randomized traffic against the array model.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      bus.RegWrite      = 1'($urandom_range(0, 1));
      bus.WriteRegister = 5'($urandom_range(0, 31));
      bus.WriteData     = {$urandom, $urandom};
      bus.ReadRegister1 = ($urandom_range(0, 3) == 0) ? bus.WriteRegister : 5'($urandom_range(0, 31));
      bus.ReadRegister2 = 5'($urandom_range(0, 31));
      #1;
      check("rand_p1", bus.ReadData1, expect_rd(bus.ReadRegister1));
      check("rand_p2", bus.ReadData2, expect_rd(bus.ReadRegister2));
      @(posedge clk);
      if (bus.RegWrite && bus.WriteRegister != 5'd31) model[bus.WriteRegister] = bus.WriteData;
    end
    #1 bus.RegWrite = 1'b0;

    // Fill, then async reset between edges.
    for (int i = 0; i < 31; i++) wr(5'(i), 64'(i), 1'b1);
    rd("fill_x30_x1", 5'd30, 5'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
    check_all_zero("reset_mid_run");
    @(negedge clk);
    reset = 1'b0;
    wr(5'd2, 64'h3, 1'b1);
    rd("x2_after_reset", 5'd2, 5'd3);
    check("x2_value", bus.ReadData1, 64'h3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
